// File: rtl/cpu_pkg.sv
// Shared types, field positions and helpers for the 16-bit pipelined CPU.
// Imported by the decode stage, its instruction decoder and the hazard unit.
package cpu_pkg;

  localparam int DATA_W     = 16;
  localparam int REG_ADDR_W = 3;
  localparam int OPCODE_W   = 4;

  // Bit positions of the instruction fields
  localparam int OPCODE_LSB  = 0;
  localparam int IMM_SEL_BIT = 4;
  localparam int RX_LSB      = 5;
  localparam int RY_LSB      = 8;
  localparam int IMM8_LSB    = 8;
  localparam int JOFF_LSB    = 5;
  localparam int SIGN_BIT    = DATA_W - 1;

  typedef enum logic [OPCODE_W-1:0] {
    MV   = 4'h0,
    ADD  = 4'h1,
    SUB  = 4'h2,
    CMP  = 4'h3,
    LD   = 4'h4,
    ST   = 4'h5,
    MVHI = 4'h6,
    JR   = 4'h8,
    JZR  = 4'h9,
    JNR  = 4'hA,
    CALL = 4'hC
  } opcode_t;

  typedef enum logic {
    EMPTY = 1'b0,
    HELD  = 1'b1
  } hold_state_t;

  // Opcodes that have no instruction assigned to them
  function automatic logic is_illegal_op(input logic [OPCODE_W-1:0] op);
    return op inside {4'h7, 4'hB, 4'hD, 4'hE, 4'hF};
  endfunction

endpackage

// File: rtl/stage_decode_if.sv
// Bus between fetch/imem/hazard logic and the decode stage, plus the decoded
// outputs presented to execute and the register file.
interface stage_decode_if;
  import cpu_pkg::*;

  logic                  valid_in;
  logic [DATA_W-1:0]     pc_in;
  logic [DATA_W-1:0]     i_pc_rddata;
  logic                  stall;
  logic                  branch_sig;

  logic                  valid_out;
  logic [DATA_W-1:0]     pc_out;
  logic [DATA_W-1:0]     instr_out;
  logic [OPCODE_W-1:0]   opcode;
  logic                  imm_sel;
  logic [REG_ADDR_W-1:0] rf_rx_addr;
  logic [REG_ADDR_W-1:0] rf_ry_addr;
  logic [DATA_W-1:0]     imm16;
  logic [DATA_W-1:0]     jmp_off16;
  logic                  illegal_op;

  // Environment side: fetch, imem and hazard unit drive, execute consumes
  modport master (
    output valid_in, pc_in, i_pc_rddata, stall, branch_sig,
    input  valid_out, pc_out, instr_out, opcode, imm_sel,
           rf_rx_addr, rf_ry_addr, imm16, jmp_off16, illegal_op
  );

  // Decode stage side
  modport slave (
    input  valid_in, pc_in, i_pc_rddata, stall, branch_sig,
    output valid_out, pc_out, instr_out, opcode, imm_sel,
           rf_rx_addr, rf_ry_addr, imm16, jmp_off16, illegal_op
  );

endinterface

// File: rtl/stage_decode_instr_decoder.sv
// Purely combinational instruction field decoder. Also instantiated by the
// hazard unit so both places agree on field extraction.
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [DATA_W-1:0]     instr,
  output logic [OPCODE_W-1:0]   opcode,
  output logic                  imm_sel,
  output logic [REG_ADDR_W-1:0] rf_rx_addr,
  output logic [REG_ADDR_W-1:0] rf_ry_addr,
  output logic [DATA_W-1:0]     imm16,
  output logic [DATA_W-1:0]     jmp_off16
);

  assign opcode     = instr[OPCODE_LSB +: OPCODE_W];
  assign imm_sel    = instr[IMM_SEL_BIT];
  assign rf_rx_addr = instr[RX_LSB +: REG_ADDR_W];
  assign rf_ry_addr = instr[RY_LSB +: REG_ADDR_W];

  // Upper byte sign-extended to a full word
  assign imm16 = {{(DATA_W - IMM8_LSB){instr[SIGN_BIT]}}, instr[DATA_W-1:IMM8_LSB]};

  // 11-bit word offset turned into a sign-extended byte offset
  assign jmp_off16 = {{(JOFF_LSB - 1){instr[SIGN_BIT]}}, instr[DATA_W-1:JOFF_LSB], 1'b0};

endmodule

// File: rtl/stage_decode.sv
// Decode stage of the 16-bit pipelined CPU. Registers the fetched PC/valid,
// picks up the imem word one cycle after the read, holds it across stalls
// and drops it on a branch flush.
// Optional feature macro: DECODE_ILLEGAL_TRAP_EN turns illegal opcodes into
// bubbles and raises illegal_op; without it illegal_op is tied low.
module stage_decode
  import cpu_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  stage_decode_if.slave bus
);

  logic              d_valid;
  logic [DATA_W-1:0] d_pc;
  logic [DATA_W-1:0] hold_instr;
  logic              rd_fresh;
  hold_state_t       state;
  logic [DATA_W-1:0] instr_cur;

  // Pipeline register: flush beats stall beats advance; rd_fresh marks a live imem word
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      d_valid  <= 1'b0;
      d_pc     <= '0;
      rd_fresh <= 1'b0;
    end else begin
      rd_fresh <= bus.valid_in & ~bus.stall & ~bus.branch_sig;
      if (bus.branch_sig) begin
        d_valid <= 1'b0;
      end else if (!bus.stall) begin
        d_valid <= bus.valid_in;
        d_pc    <= bus.pc_in;
      end
    end
  end

  // Hold FSM: latch the imem word when a stall arrives so it is never re-read
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= EMPTY;
      hold_instr <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (bus.stall && rd_fresh && !bus.branch_sig) begin
            state      <= HELD;
            hold_instr <= bus.i_pc_rddata;
          end
        end
        HELD: begin
          if (!bus.stall || bus.branch_sig) begin
            state <= EMPTY;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  // Current instruction: live imem data only when it is fresh and not already held
  always_comb begin
    instr_cur = hold_instr;
    if (state == EMPTY && rd_fresh) begin
      instr_cur = bus.i_pc_rddata;
    end
  end

  assign bus.pc_out    = d_pc;
  assign bus.instr_out = instr_cur;

  instr_decoder u_instr_decoder (
    .instr      (instr_cur),
    .opcode     (bus.opcode),
    .imm_sel    (bus.imm_sel),
    .rf_rx_addr (bus.rf_rx_addr),
    .rf_ry_addr (bus.rf_ry_addr),
    .imm16      (bus.imm16),
    .jmp_off16  (bus.jmp_off16)
  );

`ifdef DECODE_ILLEGAL_TRAP_EN
  logic illegal;
  assign illegal        = d_valid & is_illegal_op(instr_cur[OPCODE_LSB +: OPCODE_W]);
  assign bus.illegal_op = illegal;
  assign bus.valid_out  = d_valid & ~bus.branch_sig & ~illegal;
`else
  assign bus.illegal_op = 1'b0;
  assign bus.valid_out  = d_valid & ~bus.branch_sig;
`endif

endmodule

// File: tb/tb_stage_decode.sv
// Self-checking bench for stage_decode: directed scenarios with literal
// expectations followed by randomized fetch/stall/flush traffic compared
// against a behavioural model of the decode slot.
module tb_stage_decode;

  logic clk = 1'b0;
  logic reset_n;

  stage_decode_if bus ();

  stage_decode dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

`ifdef DECODE_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic [15:0] mem [256];

  int n_checks = 0;
  int n_pass   = 0;

  // Model: the decode slot holds (valid, pc); its word is whatever imem holds at pc
  logic        m_valid;
  logic [15:0] m_pc;
  logic        prev_v;
  logic [15:0] prev_pc;

  logic        cur_v;
  logic        cur_st;
  logic        cur_br;
  logic [15:0] cur_pc;

  function automatic logic op_illegal(input logic [15:0] w);
    int op;
    op = int'(w % 16);
    return (op == 7) || (op == 11) || (op >= 13);
  endfunction

  task automatic checkVal(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic checkZeros(input string tag);
    checkVal({tag, " valid_out"},  16'(bus.valid_out),  16'h0);
    checkVal({tag, " pc_out"},     bus.pc_out,          16'h0);
    checkVal({tag, " instr_out"},  bus.instr_out,       16'h0);
    checkVal({tag, " opcode"},     16'(bus.opcode),     16'h0);
    checkVal({tag, " imm_sel"},    16'(bus.imm_sel),    16'h0);
    checkVal({tag, " rf_rx_addr"}, 16'(bus.rf_rx_addr), 16'h0);
    checkVal({tag, " rf_ry_addr"}, 16'(bus.rf_ry_addr), 16'h0);
    checkVal({tag, " imm16"},      bus.imm16,           16'h0);
    checkVal({tag, " jmp_off16"},  bus.jmp_off16,       16'h0);
    checkVal({tag, " illegal_op"}, 16'(bus.illegal_op), 16'h0);
  endtask

  // Compare every output against the model for the current cycle
  task automatic checkOutput();
    logic [15:0]        w;
    logic signed [15:0] sw;
    logic signed [15:0] e_imm;
    logic signed [15:0] e_jmp;
    logic               ill;
    logic               ev;
    logic               ei;
    w     = mem[m_pc[8:1]];
    sw    = w;
    e_imm = sw >>> 8;
    e_jmp = (sw >>> 5) * 16'sd2;
    ill   = m_valid && op_illegal(w);
    ev    = m_valid && !cur_br && !(TRAP_EN && ill);
    ei    = TRAP_EN && ill;
    checkVal("model valid_out",  16'(bus.valid_out),  16'(ev));
    checkVal("model illegal_op", 16'(bus.illegal_op), 16'(ei));
    if (ev) begin
      checkVal("model pc_out",     bus.pc_out,          m_pc);
      checkVal("model instr_out",  bus.instr_out,       w);
      checkVal("model opcode",     16'(bus.opcode),     w % 16);
      checkVal("model imm_sel",    16'(bus.imm_sel),    (w / 16) % 2);
      checkVal("model rf_rx_addr", 16'(bus.rf_rx_addr), (w / 32) % 8);
      checkVal("model rf_ry_addr", 16'(bus.rf_ry_addr), (w / 256) % 8);
      checkVal("model imm16",      bus.imm16,           e_imm);
      checkVal("model jmp_off16",  bus.jmp_off16,       e_jmp);
    end
  endtask

  // Drive one cycle of inputs on the falling edge, then sample and compare
  task automatic applyStimulus(input logic v, input logic [15:0] pc, input logic st, input logic br);
    @(negedge clk);
    cur_v  = v;
    cur_pc = pc;
    cur_st = st;
    cur_br = br;
    bus.valid_in    = v;
    bus.pc_in       = pc;
    bus.stall       = st;
    bus.branch_sig  = br;
    bus.i_pc_rddata = prev_v ? mem[prev_pc[8:1]] : 16'($urandom);
    #2;
    checkOutput();
  endtask

  // Advance the model across the rising edge
  task automatic endCycle();
    @(posedge clk);
    #1;
    if (cur_br) begin
      m_valid = 1'b0;
    end else if (!cur_st) begin
      m_valid = cur_v;
      m_pc    = cur_pc;
    end
    prev_v  = cur_v;
    prev_pc = cur_pc;
  endtask

  task automatic idleInputs();
    cur_v = 1'b0; cur_st = 1'b0; cur_br = 1'b0; cur_pc = 16'h0;
    bus.valid_in = 1'b0; bus.pc_in = 16'h0; bus.stall = 1'b0;
    bus.branch_sig = 1'b0; bus.i_pc_rddata = 16'h0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    mem[0]  = 16'h1021;
    mem[1]  = 16'h2042;
    mem[2]  = 16'hF8E1;
    mem[3]  = 16'h1234;
    mem[4]  = 16'h6D52;
    mem[5]  = 16'h0A66;
    mem[8]  = 16'h3163;
    mem[10] = 16'h4A85;
    mem[13] = 16'h5BC4;
    mem[15] = 16'h000F;
    mem[16] = 16'h2C41;

    idleInputs();
    m_valid = 1'b0; m_pc = 16'h0; prev_v = 1'b0; prev_pc = 16'h0;
    reset_n = 1'b0;
    #1;
    checkZeros("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    endCycle();

    // Back-to-back fetches, one instruction per cycle
    applyStimulus(1'b1, 16'h0000, 1'b0, 1'b0); endCycle();
    applyStimulus(1'b1, 16'h0002, 1'b0, 1'b0);
    checkVal("t1 valid_out", 16'(bus.valid_out), 16'h1);
    checkVal("t1 pc_out0", bus.pc_out, 16'h0000);
    checkVal("t1 instr0", bus.instr_out, 16'h1021);
    checkVal("t1 rx", 16'(bus.rf_rx_addr), 16'h1);
    checkVal("t1 ry", 16'(bus.rf_ry_addr), 16'h0);
    endCycle();
    applyStimulus(1'b1, 16'h0004, 1'b0, 1'b0);
    checkVal("t1 pc_out1", bus.pc_out, 16'h0002);
    checkVal("t1 instr1", bus.instr_out, 16'h2042);
    endCycle();

    // Three-cycle stall: word stays put for four cycles while rddata moves on
    applyStimulus(1'b1, 16'h0006, 1'b1, 1'b0);
    checkVal("t2 instr c0", bus.instr_out, 16'hF8E1);
    checkVal("t2 imm16", bus.imm16, 16'hFFF8);
    checkVal("t2 jmp_off16", bus.jmp_off16, 16'hFF8E);
    endCycle();
    applyStimulus(1'b1, 16'h0008, 1'b1, 1'b0);
    checkVal("t2 instr c1", bus.instr_out, 16'hF8E1);
    endCycle();
    applyStimulus(1'b1, 16'h000A, 1'b1, 1'b0);
    checkVal("t2 instr c2", bus.instr_out, 16'hF8E1);
    endCycle();
    applyStimulus(1'b1, 16'h000C, 1'b0, 1'b0);
    checkVal("t2 instr c3", bus.instr_out, 16'hF8E1);
    checkVal("t2 pc c3", bus.pc_out, 16'h0004);
    endCycle();

    // Branch flush while an instruction is valid
    applyStimulus(1'b1, 16'h000E, 1'b0, 1'b1);
    checkVal("t3 valid flush", 16'(bus.valid_out), 16'h0);
    endCycle();
    applyStimulus(1'b1, 16'h0010, 1'b0, 1'b0);
    checkVal("t3 valid after", 16'(bus.valid_out), 16'h0);
    endCycle();
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
    checkVal("t3 valid next", 16'(bus.valid_out), 16'h1);
    checkVal("t3 pc next", bus.pc_out, 16'h0010);
    checkVal("t3 instr next", bus.instr_out, 16'h3163);
    endCycle();

    // Stall and flush together while a word is held
    applyStimulus(1'b1, 16'h0014, 1'b0, 1'b0); endCycle();
    applyStimulus(1'b1, 16'h0016, 1'b1, 1'b0);
    checkVal("t4 instr held", bus.instr_out, 16'h4A85);
    endCycle();
    applyStimulus(1'b1, 16'h0018, 1'b1, 1'b1);
    checkVal("t4 valid flush", 16'(bus.valid_out), 16'h0);
    endCycle();
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
    checkVal("t4 valid after", 16'(bus.valid_out), 16'h0);
    endCycle();
    applyStimulus(1'b1, 16'h001A, 1'b0, 1'b0); endCycle();
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
    checkVal("t4 pc next", bus.pc_out, 16'h001A);
    checkVal("t4 instr next", bus.instr_out, 16'h5BC4);
    endCycle();

    // Illegal opcode word
    applyStimulus(1'b1, 16'h001E, 1'b0, 1'b0); endCycle();
    applyStimulus(1'b1, 16'h0020, 1'b0, 1'b0);
    checkVal("t6 instr", bus.instr_out, 16'h000F);
    checkVal("t6 valid_out", 16'(bus.valid_out), TRAP_EN ? 16'h0 : 16'h1);
    checkVal("t6 illegal_op", 16'(bus.illegal_op), TRAP_EN ? 16'h1 : 16'h0);
    endCycle();

    // Asynchronous reset in the middle of traffic
    applyStimulus(1'b1, 16'h0022, 1'b0, 1'b0);
    checkVal("t5 pre pc", bus.pc_out, 16'h0020);
    checkVal("t5 pre instr", bus.instr_out, 16'h2C41);
    endCycle();
    #2;
    reset_n = 1'b0;
    #1;
    checkVal("t5 valid_out", 16'(bus.valid_out), 16'h0);
    checkVal("t5 pc_out", bus.pc_out, 16'h0);
    checkVal("t5 instr_out", bus.instr_out, 16'h0);
    idleInputs();
    m_valid = 1'b0; prev_v = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    endCycle();

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(0, 3) != 0,
                    16'($urandom_range(0, 255) * 2),
                    $urandom_range(0, 3) == 0,
                    $urandom_range(0, 9) == 0);
      endCycle();
    end

    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
